// File: rtl/chisq_pkg.sv
// Shared types and constants for the chi-square candidate selector.
// Holds default widths, the saturation code, FSM states and the result record.
package chisq_pkg;

    localparam int CHISQBITS_DEFAULT = 32;
    localparam int IDBITS_DEFAULT    = 10;
    localparam int CNTBITS_DEFAULT   = 8;

    // All-ones chi-square marks a saturated/overflowed value.
    localparam logic [CHISQBITS_DEFAULT-1:0] CHISQ_SAT = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic [CHISQBITS_DEFAULT-1:0] best_chisq;
        logic [IDBITS_DEFAULT-1:0]    best_id;
        logic [CNTBITS_DEFAULT-1:0]   n_pass;
        logic                         none_pass;
    } result_t;

endpackage

// File: rtl/chisq_select_if.sv
// Candidate input stream and group-result output handshake.
// master drives candidates and out_ready; slave is the selector.
interface chisq_select_if
    import chisq_pkg::*;
#(
    parameter int CHISQBITS = CHISQBITS_DEFAULT,
    parameter int IDBITS    = IDBITS_DEFAULT,
    parameter int CNTBITS   = CNTBITS_DEFAULT
);

    logic [CHISQBITS-1:0] chisq;
    logic                 chisq_dv;
    logic [IDBITS-1:0]    cand_id;
    logic                 last;
    logic [CHISQBITS-1:0] thr;
    logic                 out_ready;

    logic                 out_valid;
    logic [CHISQBITS-1:0] best_chisq;
    logic [IDBITS-1:0]    best_id;
    logic [CNTBITS-1:0]   n_pass;
    logic                 none_pass;
    logic                 lost;

    modport master (
        output chisq, chisq_dv, cand_id, last, thr, out_ready,
        input  out_valid, best_chisq, best_id, n_pass, none_pass, lost
    );

    modport slave (
        input  chisq, chisq_dv, cand_id, last, thr, out_ready,
        output out_valid, best_chisq, best_id, n_pass, none_pass, lost
    );

endinterface

// File: rtl/chisq_result_fifo.sv
// Two-entry result FIFO; head entry is always visible on dout.
// A push on a full FIFO succeeds only if a pop happens in the same cycle.
module chisq_result_fifo #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         overflow
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;
    logic         do_push;

    // Pointer/count update; pop is evaluated first so a full FIFO can take a push.
    always_comb begin
        mem_d    = mem_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        do_pop   = pop && (cnt_q != 2'd0);
        do_push  = push && ((cnt_q != 2'd2) || do_pop);
        overflow = push && !do_push;
        if (do_pop) begin
            rd_d = ~rd_q;
        end
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = ~wr_q;
        end
        cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage and pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '{RST_VAL, RST_VAL};
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid = (cnt_q != 2'd0);
    assign dout  = mem_q[rd_q];

endmodule

// File: rtl/chisq_select.sv
// Picks the minimum passing chi-square per candidate group and queues
// one result record per group into a two-entry output FIFO.
module chisq_select
    import chisq_pkg::*;
#(
    parameter int CHISQBITS = CHISQBITS_DEFAULT,
    parameter int IDBITS    = IDBITS_DEFAULT,
    parameter int CNTBITS   = CNTBITS_DEFAULT
) (
    input logic           clock,
    input logic           reset,
    chisq_select_if.slave bus
);

    typedef struct packed {
        logic [CHISQBITS-1:0] best_chisq;
        logic [IDBITS-1:0]    best_id;
        logic [CNTBITS-1:0]   n_pass;
        logic                 none_pass;
    } res_t;

    localparam int                   RES_W   = $bits(res_t);
    localparam logic [CHISQBITS-1:0] SAT     = '1;
    localparam logic [CNTBITS-1:0]   CNT_MAX = '1;
    localparam res_t RES_IDLE = '{
        best_chisq: SAT,
        best_id:    '0,
        n_pass:     '0,
        none_pass:  1'b0
    };

    state_t               state_q, state_d;
    logic [CHISQBITS-1:0] thr_q, thr_d;
    logic [CHISQBITS-1:0] best_q, best_d;
    logic [IDBITS-1:0]    id_q, id_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic                 lost_q, lost_d;

    logic                 idle;
    logic [CHISQBITS-1:0] g_thr;
    logic                 pass;
    logic [CHISQBITS-1:0] base_best;
    logic [IDBITS-1:0]    base_id;
    logic [CNTBITS-1:0]   base_cnt;
    logic [CHISQBITS-1:0] f_best;
    logic [IDBITS-1:0]    f_id;
    logic [CNTBITS-1:0]   f_cnt;
    logic                 push;
    res_t                 push_res;
    logic                 fifo_valid;
    logic [RES_W-1:0]     fifo_dout;
    logic                 overflow;
    res_t                 head;

    // Fold the current candidate into the group and decide next state.
    always_comb begin
        state_d  = state_q;
        thr_d    = thr_q;
        best_d   = best_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        idle     = (state_q == ST_IDLE);
        g_thr    = idle ? bus.thr : thr_q;
        base_best = idle ? SAT : best_q;
        base_id   = idle ? '0 : id_q;
        base_cnt  = idle ? '0 : cnt_q;
        pass     = (bus.chisq != SAT) && (bus.chisq <= g_thr);
        f_best   = base_best;
        f_id     = base_id;
        f_cnt    = base_cnt;
        if (pass && (bus.chisq < base_best)) begin
            f_best = bus.chisq;
            f_id   = bus.cand_id;
        end
        if (pass && (base_cnt != CNT_MAX)) begin
            f_cnt = base_cnt + CNTBITS'(1);
        end
        push_res = '{
            best_chisq: f_best,
            best_id:    f_id,
            n_pass:     f_cnt,
            none_pass:  (f_cnt == '0)
        };
        if (bus.chisq_dv) begin
            if (bus.last) begin
                push    = 1'b1;
                state_d = ST_IDLE;
                best_d  = SAT;
                id_d    = '0;
                cnt_d   = '0;
            end else begin
                state_d = ST_ACCUM;
                thr_d   = g_thr;
                best_d  = f_best;
                id_d    = f_id;
                cnt_d   = f_cnt;
            end
        end
        lost_d = lost_q | overflow;
    end

    // Group accumulator, FSM state and sticky drop flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            thr_q   <= '0;
            best_q  <= SAT;
            id_q    <= '0;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            best_q  <= best_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
        end
    end

    chisq_result_fifo #(
        .W       (RES_W),
        .RST_VAL (RES_IDLE)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .din      (push_res),
        .pop      (bus.out_ready),
        .valid    (fifo_valid),
        .dout     (fifo_dout),
        .overflow (overflow)
    );

    assign head           = fifo_dout;
    assign bus.out_valid  = fifo_valid;
    assign bus.best_chisq = head.best_chisq;
    assign bus.best_id    = head.best_id;
    assign bus.n_pass     = head.n_pass;
    assign bus.none_pass  = head.none_pass;
    assign bus.lost       = lost_q;

endmodule

// File: tb/tb_chisq_select.sv
// Self-checking bench for chisq_select: vector table, directed
// group sequences and a random run against a group-level model.
module tb_chisq_select;
    import chisq_pkg::*;

    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    chisq_select_if #(.CHISQBITS(32), .IDBITS(10), .CNTBITS(8)) bus ();

    chisq_select #(.CHISQBITS(32), .IDBITS(10), .CNTBITS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] c;
        logic [31:0] t;
        logic [9:0]  id;
        logic [31:0] eb;
        logic [9:0]  eid;
        logic [7:0]  en;
        logic        enone;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic [9:0]  id;
    } cand_t;

    vec_t        tbl [6];
    cand_t       grp [$];
    logic [31:0] gthr;
    result_t     expq [$];
    bit          exp_lost;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic chk_res(input string name, input logic [31:0] b,
                           input logic [9:0] id, input logic [7:0] n,
                           input logic none);
        chk({name, ".valid"}, 64'(bus.out_valid), 64'(1));
        chk({name, ".best"}, 64'(bus.best_chisq), 64'(b));
        chk({name, ".id"}, 64'(bus.best_id), 64'(id));
        chk({name, ".n"}, 64'(bus.n_pass), 64'(n));
        chk({name, ".none"}, 64'(bus.none_pass), 64'(none));
    endtask

    // Present one candidate for exactly one clock edge.
    task automatic cand(input logic [31:0] c, input logic [9:0] id,
                        input logic lst, input logic [31:0] t);
        bus.chisq    = c;
        bus.cand_id  = id;
        bus.last     = lst;
        bus.thr      = t;
        bus.chisq_dv = 1'b1;
        @(posedge clock);
        #1;
        bus.chisq_dv = 1'b0;
        bus.last     = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic result_t close_group();
        result_t r;
        int n;
        r.best_chisq = CHISQ_SAT;
        r.best_id    = '0;
        n = 0;
        foreach (grp[i]) begin
            if (grp[i].c != CHISQ_SAT && grp[i].c <= gthr) begin
                n++;
                if (grp[i].c < r.best_chisq) begin
                    r.best_chisq = grp[i].c;
                    r.best_id    = grp[i].id;
                end
            end
        end
        r.n_pass    = (n > 255) ? 8'd255 : 8'(n);
        r.none_pass = (n == 0);
        return r;
    endfunction

    task automatic rand_cycle();
        logic        dv, lst, rdy;
        logic [31:0] c, t;
        logic [9:0]  id;
        result_t     r;
        dv  = ($urandom_range(0, 3) != 0);
        lst = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        c   = ($urandom_range(0, 9) == 0) ? CHISQ_SAT : 32'($urandom_range(0, 120));
        t   = 32'($urandom_range(0, 100));
        id  = 10'($urandom_range(0, 1023));
        bus.chisq     = c;
        bus.cand_id   = id;
        bus.last      = lst;
        bus.thr       = t;
        bus.chisq_dv  = dv;
        bus.out_ready = rdy;
        @(posedge clock);
        #1;
        if (expq.size() != 0 && rdy) void'(expq.pop_front());
        if (dv) begin
            if (grp.size() == 0) gthr = t;
            grp.push_back('{c: c, id: id});
            if (lst) begin
                r = close_group();
                grp.delete();
                if (expq.size() < 2) expq.push_back(r);
                else exp_lost = 1'b1;
            end
        end
        chk("rnd.valid", 64'(bus.out_valid), 64'(expq.size() != 0));
        chk("rnd.lost", 64'(bus.lost), 64'(exp_lost));
        if (expq.size() != 0) begin
            chk("rnd.best", 64'(bus.best_chisq), 64'(expq[0].best_chisq));
            chk("rnd.id", 64'(bus.best_id), 64'(expq[0].best_id));
            chk("rnd.n", 64'(bus.n_pass), 64'(expq[0].n_pass));
            chk("rnd.none", 64'(bus.none_pass), 64'(expq[0].none_pass));
        end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        clock         = 1'b0;
        reset         = 1'b0;
        bus.chisq     = '0;
        bus.chisq_dv  = 1'b0;
        bus.cand_id   = '0;
        bus.last      = 1'b0;
        bus.thr       = '0;
        bus.out_ready = 1'b1;
        exp_lost      = 1'b0;

        tbl[0] = '{32'd10, 32'd20, 10'd3, 32'd10, 10'd3, 8'd1, 1'b0};
        tbl[1] = '{32'd20, 32'd20, 10'd4, 32'd20, 10'd4, 8'd1, 1'b0};
        tbl[2] = '{32'd21, 32'd20, 10'd5, CHISQ_SAT, 10'd0, 8'd0, 1'b1};
        tbl[3] = '{CHISQ_SAT, CHISQ_SAT, 10'd6, CHISQ_SAT, 10'd0, 8'd0, 1'b1};
        tbl[4] = '{32'd0, 32'd0, 10'd1023, 32'd0, 10'd1023, 8'd1, 1'b0};
        tbl[5] = '{32'hFFFF_FFFE, CHISQ_SAT, 10'd8, 32'hFFFF_FFFE, 10'd8, 8'd1, 1'b0};

        idle_cycle();
        chk("rst.valid", 64'(bus.out_valid), 64'(0));
        chk("rst.best", 64'(bus.best_chisq), 64'(CHISQ_SAT));
        chk("rst.id", 64'(bus.best_id), 64'(0));
        chk("rst.n", 64'(bus.n_pass), 64'(0));
        chk("rst.none", 64'(bus.none_pass), 64'(0));
        chk("rst.lost", 64'(bus.lost), 64'(0));
        reset = 1'b1;
        idle_cycle();

        for (int i = 0; i < 6; i++) begin
            cand(tbl[i].c, tbl[i].id, 1'b1, tbl[i].t);
            chk_res($sformatf("tbl%0d", i), tbl[i].eb, tbl[i].eid,
                    tbl[i].en, tbl[i].enone);
        end
        idle_cycle();
        chk("tbl.drain", 64'(bus.out_valid), 64'(0));

        cand(32'd50, 10'd1, 1'b0, 32'd40);
        cand(32'd20, 10'd2, 1'b0, 32'd40);
        chk("basic.open", 64'(bus.out_valid), 64'(0));
        cand(32'd30, 10'd3, 1'b1, 32'd40);
        chk_res("basic", 32'd20, 10'd2, 8'd2, 1'b0);

        cand(32'd100, 10'd1, 1'b0, 32'd80);
        cand(CHISQ_SAT, 10'd2, 1'b1, 32'd80);
        chk_res("nopass", CHISQ_SAT, 10'd0, 8'd0, 1'b1);

        cand(32'd25, 10'd7, 1'b0, 32'd25);
        cand(32'd25, 10'd9, 1'b1, 32'd25);
        chk_res("tie", 32'd25, 10'd7, 8'd2, 1'b0);

        cand(32'd50, 10'd1, 1'b0, 32'd40);
        cand(32'd30, 10'd2, 1'b1, 32'd10);
        chk_res("thrlatch", 32'd30, 10'd2, 8'd1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            cand(32'(500 + (i % 7)), 10'(i), (i == 299), 32'd2000);
        end
        chk_res("sat", 32'd500, 10'd0, 8'd255, 1'b0);

        idle_cycle();
        bus.out_ready = 1'b0;
        cand(32'd5, 10'd1, 1'b1, 32'd100);
        cand(32'd6, 10'd2, 1'b1, 32'd100);
        cand(32'd7, 10'd3, 1'b1, 32'd100);
        chk_res("full.h1", 32'd5, 10'd1, 8'd1, 1'b0);
        chk("full.lost", 64'(bus.lost), 64'(1));
        idle_cycle();
        chk("full.hold", 64'(bus.best_id), 64'(1));
        bus.out_ready = 1'b1;
        idle_cycle();
        chk_res("full.h2", 32'd6, 10'd2, 8'd1, 1'b0);
        idle_cycle();
        chk("full.empty", 64'(bus.out_valid), 64'(0));
        chk("full.sticky", 64'(bus.lost), 64'(1));

        cand(32'd3, 10'd1, 1'b0, 32'd40);
        cand(32'd4, 10'd2, 1'b0, 32'd40);
        reset = 1'b0;
        #2;
        chk("mid.rst.valid", 64'(bus.out_valid), 64'(0));
        chk("mid.rst.lost", 64'(bus.lost), 64'(0));
        reset = 1'b1;
        cand(32'd5, 10'd4, 1'b1, 32'd40);
        chk_res("mid.rst", 32'd5, 10'd4, 8'd1, 1'b0);
        idle_cycle();
        chk("mid.rst.stale", 64'(bus.out_valid), 64'(0));

        reset = 1'b0;
        #2;
        reset = 1'b1;
        grp.delete();
        expq.delete();
        exp_lost = 1'b0;
        for (int i = 0; i < 3000; i++) rand_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/chisq_select.md
CHISQ_SELECT -- requirements
Module: chisq_select

Interface
REQ-001 Parameter CHISQBITS, default 32, width of chi-square values.
REQ-002 Parameter IDBITS, default 10, width of candidate identifier.
REQ-003 Parameter CNTBITS, default 8, width of per-group pass counter.
REQ-004 Port clock  in  1  the block's only clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port chisq  in  CHISQBITS  candidate chi-square; all-ones means saturated/overflowed.
REQ-007 Port chisq_dv  in  1  chisq, cand_id and last are valid this cycle.
REQ-008 Port cand_id  in  IDBITS  identifier of the candidate carried by chisq.
REQ-009 Port last  in  1  qualified by chisq_dv; marks the final candidate of a group.
REQ-010 Port thr  in  CHISQBITS  acceptance threshold.
REQ-011 Port out_ready  in  1  downstream accepts the result when out_valid=1.
REQ-012 Port out_valid  out  1  a group result is presented.
REQ-013 Port best_chisq  out  CHISQBITS  minimum passing chi-square of the group.
REQ-014 Port best_id  out  IDBITS  cand_id of best_chisq.
REQ-015 Port n_pass  out  CNTBITS  number of passing candidates in the group, saturating.
REQ-016 Port none_pass  out  1  no candidate in the group passed.
REQ-017 Port lost  out  1  sticky: a group result was dropped.

Function
REQ-018 The block SHALL have no backpressure on its input; every chisq_dv cycle SHALL be consumed.
REQ-019 A candidate SHALL pass when chisq is not all-ones and chisq is less than or equal to the group threshold.
REQ-020 The FSM SHALL have states IDLE (no candidate of the current group seen) and ACCUM (at least one seen).
REQ-021 In IDLE with chisq_dv=1 and last=0, the block SHALL sample thr as the group threshold, initialise best from this candidate if it passes, and enter ACCUM.
REQ-022 In ACCUM with chisq_dv=1, a passing candidate SHALL replace best only when strictly less than the current best; ties keep the earlier candidate.
REQ-023 chisq_dv=1 with last=1 SHALL fold that candidate into the group, close the group, and return the FSM to IDLE the next cycle.
REQ-024 A single-candidate group (last=1 in IDLE) SHALL use the current thr and close immediately.
REQ-025 thr changes during ACCUM SHALL NOT affect the open group.
REQ-026 n_pass SHALL saturate at 2^CNTBITS-1.
REQ-027 A group with no passing candidate SHALL yield best_chisq all-ones, best_id 0, n_pass 0, none_pass 1.
REQ-028 Closed results SHALL enter a 2-entry FIFO; out_valid SHALL be 1 whenever the FIFO is non-empty, outputs showing the oldest entry.
REQ-029 Latency: the result SHALL appear on the outputs the cycle after the last sample when the FIFO was empty.
REQ-030 An entry SHALL be removed on a cycle with out_valid=1 and out_ready=1; outputs SHALL hold steady otherwise.
REQ-031 Push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-032 Push on a full FIFO without pop SHALL drop the new result and set lost, held until reset.

Reset
REQ-033 Reset SHALL force FSM to IDLE, empty the FIFO, out_valid 0, best_chisq all-ones, best_id 0, n_pass 0, none_pass 0, lost 0.
REQ-034 Reset asserted mid-group SHALL discard the open group; no result is emitted for it.

Structure
REQ-035 Package chisq_pkg SHALL hold CHISQBITS default, constant CHISQ_SAT (all-ones), FSM state type and the result record type.
REQ-036 The 2-entry result FIFO SHALL be sub-module chisq_result_fifo.

Verification
REQ-037 Group chisq 50,20,30 (ids 1,2,3), thr 40, out_ready 1 -> best 20, id 2, n_pass 2, none_pass 0, out_valid 1 cycle after last.
REQ-038 Group chisq 100, all-ones, thr 80 -> best all-ones, id 0, n_pass 0, none_pass 1.
REQ-039 Ties 25 (id 7), 25 (id 9), thr 25 -> best_id 7, n_pass 2.
REQ-040 out_ready 0, three single-candidate groups -> first two held in order, third dropped, lost 1; out_ready 1 -> two results then out_valid 0.
REQ-041 thr 40 at group start, thr 10 during ACCUM, chisq 30 -> candidate passes.
REQ-042 Reset during ACCUM after two candidates, then group 5 (last) -> single result best 5, no stale result.
